// File: rtl/seq_negate32.sv
// Multi-cycle one's-complement / two's-complement negation unit.
// One CHUNK-wide adder slice is reused across cycles with a registered ripple carry.
module seq_negate32 #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             ovf
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_reg;
   logic             op_reg;
   logic             carry_reg;
   logic [CW-1:0]    cnt;
   logic [CHUNK:0]   sum;
   logic [WIDTH-1:0] res_next;
   logic             last;

   // Current slice sum plus the result as it will look once this slice is written,
   // so the zero flag can be taken from the complete value on the final edge.
   always_comb begin
      state_next = state;
      sum        = {1'b0, ~a_reg[cnt*CHUNK +: CHUNK]} + (CHUNK+1)'(carry_reg);
      res_next   = result;
      res_next[cnt*CHUNK +: CHUNK] = sum[CHUNK-1:0];
      last       = (cnt == CW'(N-1));
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // cnt parks on the last chunk index after an operation so it never indexes past the operand.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         a_reg     <= '0;
         op_reg    <= 1'b0;
         carry_reg <= 1'b0;
         cnt       <= '0;
         done      <= 1'b0;
         result    <= '0;
         carry     <= 1'b0;
         zero      <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         state <= state_next;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg     <= a;
                  op_reg    <= op;
                  carry_reg <= op;
                  cnt       <= '0;
                  result    <= '0;
               end
            end
            RUN: begin
               result    <= res_next;
               carry_reg <= sum[CHUNK];
               if (last) begin
                  done  <= 1'b1;
                  carry <= sum[CHUNK];
                  zero  <= (res_next == '0);
                  ovf   <= op_reg & a_reg[WIDTH-1] & sum[CHUNK-1];
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == RUN);

endmodule

// File: tb/tb_seq_negate32.sv
// Bench for seq_negate32: vector table, randomized checks against an arithmetic model,
// and hand-written sequences for busy-ignore, back-to-back, mid-run reset and chunk sweep.
module tb_seq_negate32;

   logic        clk;
   logic        reset;
   logic        op;
   logic [31:0] a;
   logic        start_v [3];
   logic        busy_v  [3];
   logic        done_v  [3];
   logic [31:0] res_v   [3];
   logic        carry_v [3];
   logic        zero_v  [3];
   logic        ovf_v   [3];

   int total;
   int bad;

   // Index 0: CHUNK=1, index 1: CHUNK=8 (default), index 2: CHUNK=32.
   seq_negate32 #(.WIDTH(32), .CHUNK(1)) dut_c1 (
      .clk(clk), .reset(reset), .start(start_v[0]), .op(op), .a(a),
      .busy(busy_v[0]), .done(done_v[0]), .result(res_v[0]),
      .carry(carry_v[0]), .zero(zero_v[0]), .ovf(ovf_v[0]));

   seq_negate32 #(.WIDTH(32), .CHUNK(8)) dut_c8 (
      .clk(clk), .reset(reset), .start(start_v[1]), .op(op), .a(a),
      .busy(busy_v[1]), .done(done_v[1]), .result(res_v[1]),
      .carry(carry_v[1]), .zero(zero_v[1]), .ovf(ovf_v[1]));

   seq_negate32 #(.WIDTH(32), .CHUNK(32)) dut_c32 (
      .clk(clk), .reset(reset), .start(start_v[2]), .op(op), .a(a),
      .busy(busy_v[2]), .done(done_v[2]), .result(res_v[2]),
      .carry(carry_v[2]), .zero(zero_v[2]), .ovf(ovf_v[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        op;
      logic [31:0] a;
      logic [31:0] res;
      logic        carry;
      logic        zero;
      logic        ovf;
   } vec_t;

   vec_t vecs [6];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Starts one operation on DUT sel, returns once done is seen (sampled on negedges)
   // and reports how many sampled cycles busy was high.
   task automatic applyStimulus(input int sel, input logic o, input logic [31:0] v,
                                output int lat, output logic seen);
      @(negedge clk);
      op = o;
      a  = v;
      start_v[sel] = 1'b1;
      @(posedge clk);
      #1 start_v[sel] = 1'b0;
      lat  = 0;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done_v[sel]) begin
            seen = 1'b1;
            break;
         end
         if (busy_v[sel]) lat++;
      end
      checkOutput($sformatf("done_seen_%0d", sel), 32'(seen), 32'd1);
   endtask

   task automatic checkResult(input int sel, input string tag, input logic [31:0] res,
                              input logic c, input logic z, input logic ov);
      checkOutput({tag, "_result"}, res_v[sel], res);
      checkOutput({tag, "_carry"}, 32'(carry_v[sel]), 32'(c));
      checkOutput({tag, "_zero"}, 32'(zero_v[sel]), 32'(z));
      checkOutput({tag, "_ovf"}, 32'(ovf_v[sel]), 32'(ov));
   endtask

   initial begin
      int          lat;
      logic        seen;
      logic        ro;
      logic [31:0] rv;
      logic [31:0] ref_res;
      int          done_idx [$];
      int          done_cnt;

      total = 0;
      bad   = 0;
      reset = 1'b1;
      op    = 1'b0;
      a     = '0;
      for (int s = 0; s < 3; s++) start_v[s] = 1'b0;

      vecs[0] = '{1'b1, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 32'hA5A5F00F, 32'h5A5A0FF0, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 32'h00000000, 32'h00000000, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{1'b1, 32'h7FFFFFFF, 32'h80000001, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkResult(1, "reset", 32'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("reset_busy", 32'(busy_v[1]), 32'd0);
      checkOutput("reset_done", 32'(done_v[1]), 32'd0);
      reset = 1'b0;

      $display("[TB] vector table");
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1, vecs[i].op, vecs[i].a, lat, seen);
         checkResult(1, $sformatf("vec%0d", i), vecs[i].res, vecs[i].carry, vecs[i].zero, vecs[i].ovf);
         checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
         @(negedge clk);
         checkOutput($sformatf("vec%0d_done_pulse", i), 32'(done_v[1]), 32'd0);
         checkOutput($sformatf("vec%0d_hold", i), res_v[1], vecs[i].res);
      end

      $display("[TB] randomized vs model");
      for (int i = 0; i < 24; i++) begin
         ro = 1'($urandom_range(0, 1));
         rv = $urandom;
         if (i == 3) rv = 32'h80000000;
         if (i == 5) rv = 32'h0;
         ref_res = ro ? (32'd0 - rv) : ~rv;
         applyStimulus(1, ro, rv, lat, seen);
         checkResult(1, $sformatf("rnd%0d", i), ref_res, ro && (rv == 32'd0),
                     ref_res == 32'd0, ro && (rv == 32'h80000000));
      end

      $display("[TB] start while busy is ignored");
      @(negedge clk);
      op = 1'b1;
      a  = 32'h11111111;
      start_v[1] = 1'b1;
      @(posedge clk);
      #1 start_v[1] = 1'b0;
      @(negedge clk);
      start_v[1] = 1'b1;
      op = 1'b0;
      a  = 32'h22222222;
      @(posedge clk);
      #1 start_v[1] = 1'b0;
      a = 32'h33333333;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done_v[1]) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("ignore_done_seen", 32'(seen), 32'd1);
      checkOutput("ignore_result", res_v[1], 32'hEEEEEEEF);
      @(negedge clk);
      checkOutput("ignore_no_restart", 32'(busy_v[1]), 32'd0);

      $display("[TB] back-to-back with start held");
      @(negedge clk);
      op = 1'b0;
      a  = 32'h0F0F0F0F;
      start_v[1] = 1'b1;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (done_v[1]) begin
            done_idx.push_back(i);
            checkOutput($sformatf("b2b_result_%0d", i), res_v[1], 32'hF0F0F0F0);
         end
      end
      start_v[1] = 1'b0;
      checkOutput("b2b_count", 32'(done_idx.size()), 32'd4);
      for (int i = 1; i < done_idx.size(); i++)
         checkOutput($sformatf("b2b_spacing_%0d", i), 32'(done_idx[i] - done_idx[i-1]), 32'd5);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!busy_v[1] && !done_v[1]) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("b2b_drain", 32'(seen), 32'd1);

      $display("[TB] reset during run");
      @(negedge clk);
      op = 1'b1;
      a  = 32'h12345678;
      start_v[1] = 1'b1;
      @(posedge clk);
      #1 start_v[1] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      checkOutput("abort_busy_before", 32'(busy_v[1]), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checkOutput("abort_busy", 32'(busy_v[1]), 32'd0);
      checkOutput("abort_result", res_v[1], 32'h0);
      checkOutput("abort_done", 32'(done_v[1]), 32'd0);
      done_cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (done_v[1]) done_cnt++;
      end
      checkOutput("abort_no_done", 32'(done_cnt), 32'd0);
      applyStimulus(1, 1'b1, 32'h12345678, lat, seen);
      checkResult(1, "after_abort", 32'hEDCBA988, 1'b0, 1'b0, 1'b0);

      $display("[TB] chunk sweep");
      applyStimulus(0, 1'b1, 32'h000000FF, lat, seen);
      checkResult(0, "c1", 32'hFFFFFF01, 1'b0, 1'b0, 1'b0);
      checkOutput("c1_latency", 32'(lat), 32'd32);
      applyStimulus(1, 1'b1, 32'h000000FF, lat, seen);
      checkResult(1, "c8", 32'hFFFFFF01, 1'b0, 1'b0, 1'b0);
      checkOutput("c8_latency", 32'(lat), 32'd4);
      applyStimulus(2, 1'b1, 32'h000000FF, lat, seen);
      checkResult(2, "c32", 32'hFFFFFF01, 1'b0, 1'b0, 1'b0);
      checkOutput("c32_latency", 32'(lat), 32'd1);
      applyStimulus(2, 1'b1, 32'h80000000, lat, seen);
      checkResult(2, "c32_ovf", 32'h80000000, 1'b0, 1'b0, 1'b1);
      applyStimulus(0, 1'b1, 32'h00000000, lat, seen);
      checkResult(0, "c1_zero", 32'h00000000, 1'b1, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
